// File: rtl/sprite_coord_scheduler_if.sv
// Handshake bundle between the sprite coordinate scheduler, the 4-way coordinate mux and the
// downstream draw/collision unit.
//   frame_start / slot_enable       : pass trigger and per-slot enables
//   coord_x_in / coord_y_in         : mux output coordinates
//   selector                        : mux select
//   out_valid / out_ready           : coordinate handshake carrying out_x, out_y, out_slot
//   busy / done / overrun           : pass status
// The slave modport is the scheduler; the master modport is its environment.
interface sprite_coord_scheduler_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
);
  logic           frame_start;
  logic [3:0]     slot_enable;
  logic [X_W-1:0] coord_x_in;
  logic [Y_W-1:0] coord_y_in;
  logic [1:0]     selector;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_x;
  logic [Y_W-1:0] out_y;
  logic [1:0]     out_slot;
  logic           busy;
  logic           done;
  logic           overrun;

  modport master (
    output frame_start, slot_enable, coord_x_in, coord_y_in, out_ready,
    input  selector, out_valid, out_x, out_y, out_slot, busy, done, overrun
  );

  modport slave (
    input  frame_start, slot_enable, coord_x_in, coord_y_in, out_ready,
    output selector, out_valid, out_x, out_y, out_slot, busy, done, overrun
  );
endinterface

// File: rtl/sprite_coord_scheduler.sv
// Once per frame, walks the enabled sprite slots (0 to 3) of a 4-way coordinate mux: drives
// the mux selector, waits SETTLE_CYCLES for the mux to settle, samples X/Y and offers them
// downstream over a valid/ready handshake.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : slave side of sprite_coord_scheduler_if (trigger, mux, handshake, status)
module sprite_coord_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned X_W           = 11,
  parameter int unsigned Y_W           = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  sprite_coord_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSelect, StSettle, StOffer, StDone} state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  state_e         state_q;
  logic [3:0]     mask_q;
  logic [3:0]     cnt_q;
  logic [1:0]     selector_q;
  logic [1:0]     out_slot_q;
  logic           out_valid_q;
  logic [X_W-1:0] out_x_q;
  logic [Y_W-1:0] out_y_q;
  logic           busy_q;
  logic           done_q;
  logic           overrun_q;

  logic [1:0]     first_idx;
  logic [3:0]     mask_clr;

  // Lowest set bit of the remaining mask gives ascending slot order.
  always_comb begin
    first_idx = 2'd3;
    if (mask_q[0])      first_idx = 2'd0;
    else if (mask_q[1]) first_idx = 2'd1;
    else if (mask_q[2]) first_idx = 2'd2;
  end

  assign mask_clr = mask_q & ~(4'b0001 << out_slot_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mask_q      <= 4'd0;
      cnt_q       <= 4'd0;
      selector_q  <= 2'd0;
      out_slot_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.frame_start && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.frame_start) begin
            mask_q <= bus.slot_enable;
            busy_q <= 1'b1;
            if (|bus.slot_enable) begin
              state_q <= StSelect;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StSelect: begin
          selector_q <= first_idx;
          out_slot_q <= first_idx;
          cnt_q      <= SettleInit;
          state_q    <= StSettle;
        end
        StSettle: begin
          cnt_q <= cnt_q - 4'd1;
          // <= rather than == so an out-of-range SETTLE_CYCLES of 0 cannot wedge the pass.
          if (cnt_q <= 4'd1) begin
            out_x_q     <= bus.coord_x_in;
            out_y_q     <= bus.coord_y_in;
            out_valid_q <= 1'b1;
            state_q     <= StOffer;
          end
        end
        StOffer: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            mask_q      <= mask_clr;
            if (|mask_clr) begin
              state_q <= StSelect;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.selector  = selector_q;
  assign bus.out_slot  = out_slot_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;

endmodule
